fp_div_iter: RTL and testbench
==============================

Name: fp_div_iter

Overview:
Parametrised iterative floating-point divider: the next generation of the FP divide unit used alongside the add/sub and multiply units. One restoring quotient bit per cycle. Full valid/ready handshakes on input and output, four rounding modes, and a 5-bit IEEE exception vector. Generic over exponent and significand width, so one RTL source serves single precision and the narrower test formats.

Parameters:
EXP_BITS, 8, exponent field width; BIAS = 2^(EXP_BITS-1)-1
SIG_BITS, 23, stored fraction width (hidden bit implicit)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands a, b, rm valid
in_ready  out  1  block can accept an operation
a  in  EXP_BITS+SIG_BITS+1  dividend {sign, exp, frac}
b  in  EXP_BITS+SIG_BITS+1  divisor
rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN, 11 RUP
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
q  out  EXP_BITS+SIG_BITS+1  quotient
flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, q=0, flags=0, all datapath registers 0.
- A reset asserted mid-operation aborts the operation. No result is produced, and in_ready=1 on the first edge after rst deasserts.
- FSM states are IDLE, UNPACK, DIV, ROUND, DONE.
- IDLE: in_ready=1. When in_valid is high at a rising edge, latch a, b, rm and go to UNPACK. in_ready=0 in every state except IDLE.
- UNPACK, special-case checks:
  - exp==0 is treated as zero; denormal inputs flush to zero.
  - exp all-ones with frac!=0 is a NaN.
  - Special cases go straight to DONE.
  - Otherwise:
    - ma={1,frac_a}, mb={1,frac_b}.
    - e = ea - eb + BIAS, computed signed in EXP_BITS+2 bits.
    - If ma<mb, the dividend is shifted left 1 and e is decremented.
    - Then go to DIV.
- Special-case results:
  - Any NaN, 0/0 or inf/inf: q = canonical qNaN {0, all-ones, 1 followed by zeros}, invalid=1.
  - finite nonzero/0: q = ±inf, div_by_zero=1.
  - inf/finite: q = ±inf, no flags.
  - 0/nonzero or finite/inf: q = ±0, no flags.
- Sign of every non-NaN result = sa XOR sb.
- DIV: restoring division, exactly SIG_BITS+2 cycles. This produces quotient bits 1.f plus one guard bit. Iteration counter width is $clog2(SIG_BITS+3). sticky = (final remainder != 0).
- ROUND, one cycle:
  - Round the quotient by rm using the guard and sticky bits.
  - Mantissa carry-out: shift right and increment e.
  - inexact = guard | sticky.
  - e >= 2^EXP_BITS-1: overflow=1, inexact=1. q = ±inf for RNE; for directed modes q is ±inf or ±max-finite per IEEE.
  - e <= 0: flush to ±0 with underflow=1, inexact=1.
  - Go to DONE.
- DONE: out_valid=1. q and flags are held stable while out_ready=0. On an edge with out_ready=1: out_valid→0, go to IDLE, in_ready=1 in the following cycle. No bypass from DONE to a new accept.
- Latency, counted in rising edges from the accepting edge to out_valid=1:
  - normal operands: SIG_BITS+5 (28 at default);
  - special cases: 2.
- Throughput is one operation in flight.
- Inputs a, b, rm are ignored outside the IDLE accept edge.

Test Plan:
- Exact divide: a=0x40C00000 (6.0), b=0x40000000, rm=00 -> q=0x40400000, flags=0, out_valid exactly 28 edges after accept.
- Rounding, 1.0/3.0 (a=0x3F800000, b=0x40400000):
  - rm=00 -> q=0x3EAAAAAB, flags=00001;
  - rm=01 -> q=0x3EAAAAAA, flags=00001.
- Specials, each with 2-edge latency:
  - 0x3F800000/0x00000000 -> q=0x7F800000, flags=01000;
  - 0x00000000/0x00000000 -> q=0x7FC00000, flags=10000;
  - 0xBF800000/0x7F800000 -> q=0x80000000, flags=0.
- Overflow and underflow:
  - 0x7F7FFFFF/0x3F000000 with rm=00 -> q=0x7F800000, flags=00101;
  - same operands with rm=01 -> q=0x7F7FFFFF, flags=00101;
  - 0x00800000/0x40000000 -> q=0x00000000, flags=00011.
- Handshake: hold out_ready=0 for 10 cycles after out_valid -> q and flags stable and in_ready=0 throughout. Drive in_valid during busy -> that request is ignored.
- Reset: assert rst 10 cycles into a normal divide -> out_valid=0 and in_ready=1 immediately. After release, a new 6.0/2.0 completes correctly in 28 edges.

Source files
------------

// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative IEEE-style floating-point divider, one restoring
// quotient bit per cycle. Denormal inputs flush to zero and underflowing
// results flush to signed zero.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready operand handshake; a, b, rm sampled on accept
//   a, b                dividend / divisor {sign, exp, frac}
//   rm                  rounding mode: 00 RNE, 01 RTZ, 10 RDN, 11 RUP
//   out_valid/out_ready result handshake; q and flags held until taken
//   q                   quotient
//   flags               {invalid, div_by_zero, overflow, underflow, inexact}
module fp_div_iter #(
  parameter int EXP_BITS = 8,
  parameter int SIG_BITS = 23
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [EXP_BITS+SIG_BITS:0]   a,
  input  logic [EXP_BITS+SIG_BITS:0]   b,
  input  logic [1:0]                   rm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_BITS+SIG_BITS:0]   q,
  output logic [4:0]                   flags
);

  localparam int W  = EXP_BITS + SIG_BITS + 1;
  localparam int MW = SIG_BITS + 1;  // significand with hidden bit
  localparam int RW = SIG_BITS + 3;  // partial remainder
  localparam int QW = SIG_BITS + 2;  // 1.f plus guard
  localparam int EW = EXP_BITS + 2;  // signed working exponent
  localparam int CW = $clog2(SIG_BITS + 3);

  localparam logic [CW-1:0] LAST   = CW'(SIG_BITS + 1);
  localparam logic [EW-1:0] BIAS_E = {3'b000, {(EXP_BITS-1){1'b1}}};
  localparam logic [EW-1:0] EMAX_E = {2'b00, {EXP_BITS{1'b1}}};
  localparam logic [W-1:0]  QNAN   = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(SIG_BITS-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, DIV, ROUND, DONE} state_e;
  typedef enum logic [1:0] {RM_RNE, RM_RTZ, RM_RDN, RM_RUP} rm_e;

  state_e          r_state;
  rm_e             r_rm;
  logic [W-1:0]    r_a, r_b;
  logic            r_sign;
  logic [EW-1:0]   r_exp;
  logic [RW-1:0]   r_rem;
  logic [MW-1:0]   r_div;
  logic [QW-1:0]   r_quo;
  logic [CW-1:0]   r_cnt;

  // Operand decode
  logic [EXP_BITS-1:0] w_ea, w_eb;
  logic [SIG_BITS-1:0] w_fa, w_fb;
  logic [MW-1:0]       w_ma, w_mb;
  logic                w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  logic                w_sign, w_shift, w_special;
  logic [EW-1:0]       w_e_un;
  logic [W-1:0]        w_sp_q;
  logic [4:0]          w_sp_flags;

  always_comb begin
    w_ea     = r_a[W-2:SIG_BITS];
    w_eb     = r_b[W-2:SIG_BITS];
    w_fa     = r_a[SIG_BITS-1:0];
    w_fb     = r_b[SIG_BITS-1:0];
    w_ma     = {1'b1, w_fa};
    w_mb     = {1'b1, w_fb};
    w_sign   = r_a[W-1] ^ r_b[W-1];
    w_a_zero = (w_ea == '0);
    w_b_zero = (w_eb == '0);
    w_a_inf  = (&w_ea) && (w_fa == '0);
    w_b_inf  = (&w_eb) && (w_fb == '0);
    w_a_nan  = (&w_ea) && (|w_fa);
    w_b_nan  = (&w_eb) && (|w_fb);
    // Pre-normalise so the first quotient bit is always 1
    w_shift  = (w_ma < w_mb);
    w_e_un   = {2'b00, w_ea} - {2'b00, w_eb} + BIAS_E - {{(EW-1){1'b0}}, w_shift};

    w_special  = 1'b1;
    w_sp_q     = '0;
    w_sp_flags = '0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_sp_q     = QNAN;
      w_sp_flags = 5'b10000;
    end else if (w_b_zero && !w_a_inf) begin
      w_sp_q     = {w_sign, {EXP_BITS{1'b1}}, {SIG_BITS{1'b0}}};
      w_sp_flags = 5'b01000;
    end else if (w_a_inf) begin
      w_sp_q     = {w_sign, {EXP_BITS{1'b1}}, {SIG_BITS{1'b0}}};
    end else if (w_a_zero || w_b_inf) begin
      w_sp_q     = {w_sign, {(W-1){1'b0}}};
    end else begin
      w_special  = 1'b0;
    end
  end

  // Restoring step
  logic          w_ge;
  logic [RW-1:0] w_rnext, w_rshift;

  always_comb begin
    w_ge     = (r_rem >= {2'b00, r_div});
    w_rnext  = w_ge ? (r_rem - {2'b00, r_div}) : r_rem;
    w_rshift = w_rnext << 1;
  end

  // Rounding and range handling
  logic [MW-1:0]       w_mant;
  logic                w_g, w_s, w_lsb, w_inc, w_carry, w_to_inf;
  logic [MW:0]         w_sum;
  logic [SIG_BITS-1:0] w_frac;
  logic [EW-1:0]       w_e_r;
  logic [W-1:0]        w_rq;
  logic [4:0]          w_rf;

  always_comb begin
    w_mant = r_quo[QW-1:1];
    w_g    = r_quo[0];
    w_s    = |r_rem;
    w_lsb  = r_quo[1];
    unique case (r_rm)
      RM_RNE: w_inc = w_g & (w_s | w_lsb);
      RM_RTZ: w_inc = 1'b0;
      RM_RDN: w_inc = r_sign & (w_g | w_s);
      RM_RUP: w_inc = ~r_sign & (w_g | w_s);
    endcase
    w_sum   = {1'b0, w_mant} + {{MW{1'b0}}, w_inc};
    w_carry = w_sum[MW];
    w_frac  = w_carry ? w_sum[SIG_BITS:1] : w_sum[SIG_BITS-1:0];
    w_e_r   = r_exp + {{(EW-1){1'b0}}, w_carry};
    w_to_inf = (r_rm == RM_RNE) || (r_rm == RM_RDN && r_sign) || (r_rm == RM_RUP && !r_sign);

    w_rq = {r_sign, w_e_r[EXP_BITS-1:0], w_frac};
    w_rf = {4'b0000, w_g | w_s};
    if (w_e_r[EW-1] || w_e_r == '0) begin
      w_rq = {r_sign, {(W-1){1'b0}}};
      w_rf = 5'b00011;
    end else if (w_e_r >= EMAX_E) begin
      w_rq = w_to_inf ? {r_sign, {EXP_BITS{1'b1}}, {SIG_BITS{1'b0}}}
                      : {r_sign, {(EXP_BITS-1){1'b1}}, 1'b0, {SIG_BITS{1'b1}}};
      w_rf = 5'b00101;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rm      <= RM_RNE;
      r_a       <= '0;
      r_b       <= '0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      q         <= '0;
      flags     <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (in_valid) begin
          r_a      <= a;
          r_b      <= b;
          r_rm     <= rm_e'(rm);
          in_ready <= 1'b0;
          r_state  <= UNPACK;
        end
        UNPACK: begin
          r_sign <= w_sign;
          if (w_special) begin
            q         <= w_sp_q;
            flags     <= w_sp_flags;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_exp   <= w_e_un;
            r_rem   <= w_shift ? {1'b0, w_ma, 1'b0} : {2'b00, w_ma};
            r_div   <= w_mb;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_state <= DIV;
          end
        end
        DIV: begin
          r_rem <= w_rshift;
          r_quo <= {r_quo[QW-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= ROUND;
        end
        ROUND: begin
          q         <= w_rq;
          flags     <= w_rf;
          out_valid <= 1'b1;
          r_state   <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
module tb_fp_div_iter;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, q;
  logic [1:0]  rm;
  logic [4:0]  flags;

  always #5 clk = ~clk;

  fp_div_iter #(.EXP_BITS(8), .SIG_BITS(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .flags(flags)
  );

  typedef struct {
    logic [31:0] q;
    logic [4:0]  f;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [1:0] trm, input logic [31:0] eq, input logic [4:0] ef,
                        input int elat, input int hold, input bit poke);
    exp_t e;
    int   n;
    sb.push_back('{eq, ef, elat});
    @(negedge clk);
    a = ta; b = tb_v; rm = trm; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb_v; rm = ~trm;
    n = 1;
    chk({tag, ":busy_in_ready"}, 32'(in_ready), 32'd0);
    while (out_valid !== 1'b1 && n < 200) begin
      if (poke) begin
        in_valid = (n >= 3 && n < 6);
        a = 32'h3F800000; b = 32'h3F800000; rm = 2'b00;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    chk({tag, ":latency"}, 32'(n), 32'(e.lat));
    chk({tag, ":q"}, q, e.q);
    chk({tag, ":flags"}, 32'(flags), 32'(e.f));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ":hold_q"}, q, e.q);
      chk({tag, ":hold_flags"}, 32'(flags), 32'(e.f));
      chk({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, ":drain_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ":drain_in_ready"}, 32'(in_ready), 32'd1);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      chk({tag, ":no_phantom"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; rm = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_q", q, 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("exact_6_2",     32'h40C00000, 32'h40000000, 2'b00, 32'h40400000, 5'b00000, 28, 0, 1'b0);
    run_op("third_rne",     32'h3F800000, 32'h40400000, 2'b00, 32'h3EAAAAAB, 5'b00001, 28, 10, 1'b0);
    run_op("third_rtz",     32'h3F800000, 32'h40400000, 2'b01, 32'h3EAAAAAA, 5'b00001, 28, 0, 1'b0);
    run_op("third_rup",     32'h3F800000, 32'h40400000, 2'b11, 32'h3EAAAAAB, 5'b00001, 28, 0, 1'b0);
    run_op("negthird_rdn",  32'hBF800000, 32'h40400000, 2'b10, 32'hBEAAAAAB, 5'b00001, 28, 0, 1'b0);
    run_op("negthird_rup",  32'hBF800000, 32'h40400000, 2'b11, 32'hBEAAAAAA, 5'b00001, 28, 0, 1'b0);
    run_op("one_div_zero",  32'h3F800000, 32'h00000000, 2'b00, 32'h7F800000, 5'b01000, 2, 0, 1'b0);
    run_op("zero_div_zero", 32'h00000000, 32'h00000000, 2'b00, 32'h7FC00000, 5'b10000, 2, 0, 1'b0);
    run_op("neg_div_inf",   32'hBF800000, 32'h7F800000, 2'b00, 32'h80000000, 5'b00000, 2, 0, 1'b0);
    run_op("inf_div_two",   32'h7F800000, 32'h40000000, 2'b00, 32'h7F800000, 5'b00000, 2, 0, 1'b0);
    run_op("nan_div_one",   32'h7F812345, 32'h3F800000, 2'b00, 32'h7FC00000, 5'b10000, 2, 0, 1'b0);
    run_op("inf_div_inf",   32'hFF800000, 32'h7F800000, 2'b01, 32'h7FC00000, 5'b10000, 2, 0, 1'b0);
    run_op("denorm_flush",  32'h00400000, 32'h3F800000, 2'b00, 32'h00000000, 5'b00000, 2, 0, 1'b0);
    run_op("ovf_rne",       32'h7F7FFFFF, 32'h3F000000, 2'b00, 32'h7F800000, 5'b00101, 28, 0, 1'b0);
    run_op("ovf_rtz",       32'h7F7FFFFF, 32'h3F000000, 2'b01, 32'h7F7FFFFF, 5'b00101, 28, 0, 1'b0);
    run_op("ovf_rdn_pos",   32'h7F7FFFFF, 32'h3F000000, 2'b10, 32'h7F7FFFFF, 5'b00101, 28, 0, 1'b0);
    run_op("ovf_rup_pos",   32'h7F7FFFFF, 32'h3F000000, 2'b11, 32'h7F800000, 5'b00101, 28, 0, 1'b0);
    run_op("ovf_rdn_neg",   32'hFF7FFFFF, 32'h3F000000, 2'b10, 32'hFF800000, 5'b00101, 28, 0, 1'b0);
    run_op("unf_flush",     32'h00800000, 32'h40000000, 2'b00, 32'h00000000, 5'b00011, 28, 0, 1'b0);
    run_op("busy_poke",     32'h40C00000, 32'h40000000, 2'b00, 32'h40400000, 5'b00000, 28, 0, 1'b1);

    // Abort a divide mid-flight with reset
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; rm = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst = 1'b1; #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_q", q, 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op("after_reset",   32'h40C00000, 32'h40000000, 2'b00, 32'h40400000, 5'b00000, 28, 0, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
